norm_shift_stage: RTL
=====================

# norm_shift_stage

Pipelined normalization shifter for the rounder, directly downstream of the `flags` unit. It takes the unnormalized significand `fr` and exponent `er`, plus the `lz`, `TINY` and `OVF1` values `flags` computes from them. It left-shifts `fr` so its leading one reaches bit 56 and adjusts the exponent to match, with the shift clamped for tiny results. Results go to the significand-rounding stage through a two-stage elastic pipeline with valid/ready handshakes on both sides.

## Interface
- `SIG_W`, 57, significand width (`fr`/`fn`)
- `EXP_W`, 13, exponent width, two's complement
- `LZ_W`, 6, leading-zero-count width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream presents a beat
- `in_ready`  out  1  stage accepts a beat this cycle
- `fr`  in  57  unnormalized significand
- `er`  in  13  exponent, signed
- `db`  in  1  1 = double precision, 0 = single
- `lz`  in  6  leading-zero count of `fr`, from `flags`
- `TINY`  in  1  tiny flag, from `flags`
- `OVF1`  in  1  overflow-before-rounding flag, from `flags`
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  downstream accepts
- `fn`  out  57  normalized significand
- `en`  out  13  adjusted exponent, signed
- `out_db`  out  1  `db` passed through
- `out_tiny`  out  1  `TINY` passed through
- `out_ovf1`  out  1  `OVF1` passed through
- `out_zero`  out  1  1 when `fr` was all zeros

## Operation
- Minimum exponent is emin = −126 when `db` = 0 and −1022 when `db` = 1, as a 13-bit signed value.
- **Shift amount `sh`:**
  - When `fr` == 0: `sh` = 0, `out_zero` = 1. `lz` is ignored in this case.
  - Otherwise, when `TINY` = 0: `sh` = `lz`.
  - Otherwise, when `TINY` = 1: `sh` = max(`er` − emin, 0). This is computed as a 13-bit signed subtraction. The result is never larger than `lz`, because `TINY` implies `er` − `lz` < emin.
  - No right shift is ever performed; denormalization belongs to the downstream stage.
- **Outputs:**
  - `fn` = `fr` << `sh`, truncated to 57 bits. Zero-fill from the LSB; no bits are lost.
  - `en` = `er` − `sh`, 13-bit two's complement, wrapping on overflow. No saturation is applied; `OVF1` carries the overflow information.
- **Stage 1 (S1):** registers the inputs. Computes `sh` (6 bits) and `en`, and registers both together with the flags.
- **Stage 2 (S2):** applies the barrel shift to the S1 significand and registers `fn` together with the rest of the result.
- **Handshake (elastic pipeline, no skid buffer):**
  - adv2 = !v2 | `out_ready`
  - adv1 = !v1 | adv2
  - `in_ready` = adv1
  - An input beat is accepted when `in_valid` & `in_ready`.
  - S1 loads on adv1 and S2 loads on adv2. Each stage's valid bit takes the valid bit of the stage feeding it.
  - `out_valid` = v2. Payload is held stable while `out_valid` & !`out_ready`.
  - Accept and emit in the same cycle are allowed; throughput is 1 beat per cycle with no bubbles.
- Payload registers are loaded only when their stage advances with valid data; otherwise they hold their value.

## Timing
- Latency is 2 cycles: a beat accepted at edge N appears on `out_valid` after edge N+1 and is visible in cycle N+2.
- Capacity is 2 beats. While `out_ready` = 0 with both stages full, `in_ready` = 0, combinationally from `out_ready`.
- **Reset:**
  - While `rst` is high at an edge, v1 and v2 clear.
  - `out_valid` = 0 and `in_ready` = 1 in the cycle after reset.
  - `fn`, `en`, `out_db`, `out_tiny`, `out_ovf1` and `out_zero` all reset to 0.
  - Beats in flight when `rst` asserts are discarded. A beat presented in the same cycle as `rst` is not accepted.
- `out_valid`, once asserted, stays high until it is accepted.

## Test plan
- **Normal shift:** `fr` = 1<<53, `er` = 10, `db` = 1, `lz` = 3, `TINY` = 0 → 2 cycles later `fn` = 1<<56, `en` = 7, `out_zero` = 0.
- **Tiny clamp:** `db` = 0, `er` = −120, `fr` = 1<<46, `lz` = 10, `TINY` = 1 → `sh` = 6, `fn` = 1<<52, `en` = −126, `out_tiny` = 1.
- **Zero input:** `fr` = 0, `er` = 13'h0001, `lz` = 63, `db` = 1 → `fn` = 0, `en` = 1, `out_zero` = 1.
- **Backpressure:** hold `out_ready` = 0 and offer 3 consecutive beats A, B, C.
  - A and B are accepted; `in_ready` goes low while C is offered.
  - Raise `out_ready`: outputs come out A, B, C in order, each held stable until accepted.
  - C is accepted on the same cycle A is emitted.
- **Streaming:** `out_ready` = 1 with 8 back-to-back beats → 8 results on 8 consecutive cycles, starting 2 cycles after the first accept.
- **Reset mid-operation:** with 2 beats in flight, assert `rst` for 1 cycle → next cycle `out_valid` = 0, `in_ready` = 1, all outputs 0, and neither beat is ever emitted.

Source files
------------

// File: rtl/norm_shift_stage.sv
// Two-stage elastic normalization shifter: S1 picks the shift and adjusts the
// exponent, S2 applies the barrel shift. Both stages advance independently.
module norm_shift_stage #(
  parameter int SIG_W = 57,
  parameter int EXP_W = 13,
  parameter int LZ_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] fr,
  input  logic [EXP_W-1:0] er,
  input  logic             db,
  input  logic [LZ_W-1:0]  lz,
  input  logic             TINY,
  input  logic             OVF1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] fn,
  output logic [EXP_W-1:0] en,
  output logic             out_db,
  output logic             out_tiny,
  output logic             out_ovf1,
  output logic             out_zero
);

  localparam logic [EXP_W-1:0] EMIN_SP = EXP_W'(-126);
  localparam logic [EXP_W-1:0] EMIN_DP = EXP_W'(-1022);

  // Handshake: a stage advances when it is empty or the stage after it
  // advances. in_valid/out_valid never depend on the ready of the same side.
  logic adv1, adv2;
  logic v1_q, v2_q;

  logic [SIG_W-1:0] fr1_q;
  logic [LZ_W-1:0]  sh1_q;
  logic [EXP_W-1:0] en1_q;
  logic             db1_q, tiny1_q, ovf1_q, zero1_q;

  logic [SIG_W-1:0] fn_q;
  logic [EXP_W-1:0] en_q;
  logic             db2_q, tiny2_q, ovf2_q, zero2_q;

  logic             fr_zero;
  logic [EXP_W-1:0] emin, diff, en_d;
  logic [LZ_W-1:0]  sh_d;
  logic [SIG_W-1:0] fn_d;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Tiny results only shift as far as emin; TINY guarantees this fits in lz.
  always_comb begin
    fr_zero = (fr == '0);
    emin    = db ? EMIN_DP : EMIN_SP;
    diff    = er - emin;
    sh_d    = '0;
    if (fr_zero)        sh_d = '0;
    else if (!TINY)     sh_d = lz;
    else if (diff[EXP_W-1]) sh_d = '0;
    else                sh_d = diff[LZ_W-1:0];
    en_d    = er - {{(EXP_W-LZ_W){1'b0}}, sh_d};
  end

  assign fn_d = fr1_q << sh1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      fr1_q   <= '0;
      sh1_q   <= '0;
      en1_q   <= '0;
      db1_q   <= 1'b0;
      tiny1_q <= 1'b0;
      ovf1_q  <= 1'b0;
      zero1_q <= 1'b0;
      fn_q    <= '0;
      en_q    <= '0;
      db2_q   <= 1'b0;
      tiny2_q <= 1'b0;
      ovf2_q  <= 1'b0;
      zero2_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv1 && in_valid) begin
        fr1_q   <= fr;
        sh1_q   <= sh_d;
        en1_q   <= en_d;
        db1_q   <= db;
        tiny1_q <= TINY;
        ovf1_q  <= OVF1;
        zero1_q <= fr_zero;
      end
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        fn_q    <= fn_d;
        en_q    <= en1_q;
        db2_q   <= db1_q;
        tiny2_q <= tiny1_q;
        ovf2_q  <= ovf1_q;
        zero2_q <= zero1_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign fn        = fn_q;
  assign en        = en_q;
  assign out_db    = db2_q;
  assign out_tiny  = tiny2_q;
  assign out_ovf1  = ovf2_q;
  assign out_zero  = zero2_q;

endmodule
